// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU issue controller
// Contents: TotalALU function codes, result-kind encoding, issue FSM states,
// default parameter values and the single-cycle opcode classifier.
package alu_pkg;

  localparam int W_DEF          = 32;
  localparam int DIV_CYCLES_DEF = 33;
  localparam int DIV_SETTLE_DEF = 2;

  localparam logic [5:0] F_IDLE = 6'd0;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'd0,
    KIND_HI     = 2'd1,
    KIND_LO     = 2'd2,
    KIND_ERR    = 2'd3
  } res_kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DIV_WAIT,
    S_DIV_SETTLE,
    S_MFHI,
    S_MFLO,
    S_ERR
  } state_e;

  // Operations whose result is available from the ALU in the cycle after issue.
  function automatic logic is_basic_op(input logic [5:0] f);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - decode, TotalALU and result-consumer signals of the issue controller
// Ports (as signals): op_valid/op_ready/op_funct/op_a/op_b from decode,
// alu_dataA/alu_dataB/alu_signal/alu_out to and from TotalALU,
// res_valid/res_ready/res_data/res_kind to the result consumer.
// slave: the controller side. master: the surrounding environment.
interface alu_issue_ctrl_if #(parameter int W = 32);

  logic         op_valid;
  logic         op_ready;
  logic [5:0]   op_funct;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_dataA;
  logic [W-1:0] alu_dataB;
  logic [5:0]   alu_signal;
  logic [W-1:0] alu_out;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [1:0]   res_kind;

  modport slave (
    input  op_valid, op_funct, op_a, op_b, alu_out, res_ready,
    output op_ready, alu_dataA, alu_dataB, alu_signal, res_valid, res_data, res_kind
  );

  modport master (
    output op_valid, op_funct, op_a, op_b, alu_out, res_ready,
    input  op_ready, alu_dataA, alu_dataB, alu_signal, res_valid, res_data, res_kind
  );

endinterface

// File: rtl/alu_result_buf.sv
// rtl/alu_result_buf.sv - one-entry valid/ready result buffer
// Ports: clk, reset (async, active-high); load/load_data/load_kind capture a
// result; load_allowed says a load is accepted this cycle; res_valid/res_ready/
// res_data/res_kind form the output handshake.
module alu_result_buf
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  res_kind_e    load_kind,
  output logic         load_allowed,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_kind
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic [1:0]   kind_q, kind_d;

  // A full buffer being drained this cycle can take a new entry on the same edge.
  assign load_allowed = !valid_q || res_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    kind_d  = kind_q;
    if (load && load_allowed) begin
      valid_d = 1'b1;
      data_d  = load_data;
      kind_d  = load_kind;
    end else if (res_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      kind_q  <= KIND_NORMAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      kind_q  <= kind_d;
    end
  end

  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_kind  = kind_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue stage feeding TotalALU with a buffered result return
// Ports: clk; reset (async, active-high, shared with TotalALU);
// bus (slave): decode handshake in, ALU operands/Signal out, ALU output in,
// buffered result handshake out.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int DIV_SETTLE = DIV_SETTLE_DEF
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES + DIV_SETTLE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [5:0]       sig_q, sig_d;

  logic             load;
  logic             load_allowed;
  logic [W-1:0]     load_data;
  res_kind_e        load_kind;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sig_d     = sig_q;
    load      = 1'b0;
    load_data = bus.alu_out;
    load_kind = KIND_NORMAL;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          a_d = bus.op_a;
          b_d = bus.op_b;
          if (is_basic_op(bus.op_funct)) begin
            sig_d   = bus.op_funct;
            state_d = S_EXEC;
          end else if (bus.op_funct == F_DIVU) begin
            sig_d   = F_DIVU;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
            state_d = S_DIV_WAIT;
          end else begin
            // Unknown codes never reach the ALU; they only produce an error result.
            sig_d   = F_IDLE;
            state_d = S_ERR;
          end
        end
      end
      S_EXEC: begin
        if (load_allowed) begin
          load    = 1'b1;
          sig_d   = F_IDLE;
          state_d = S_IDLE;
        end
      end
      // The divide runs on its own timeline inside the ALU, so these two
      // countdowns never wait for the result buffer.
      S_DIV_WAIT: begin
        if (cnt_q == '0) begin
          sig_d   = F_IDLE;
          cnt_d   = CNT_W'(DIV_SETTLE - 1);
          state_d = S_DIV_SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV_SETTLE: begin
        if (cnt_q == '0) begin
          sig_d   = F_MFHI;
          state_d = S_MFHI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MFHI: begin
        if (load_allowed) begin
          load      = 1'b1;
          load_kind = KIND_HI;
          sig_d     = F_MFLO;
          state_d   = S_MFLO;
        end
      end
      S_MFLO: begin
        if (load_allowed) begin
          load      = 1'b1;
          load_kind = KIND_LO;
          sig_d     = F_IDLE;
          state_d   = S_IDLE;
        end
      end
      S_ERR: begin
        if (load_allowed) begin
          load      = 1'b1;
          load_data = '0;
          load_kind = KIND_ERR;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sig_q   <= F_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sig_q   <= sig_d;
    end
  end

  assign bus.op_ready   = (state_q == S_IDLE);
  assign bus.alu_dataA  = a_q;
  assign bus.alu_dataB  = b_q;
  assign bus.alu_signal = sig_q;

  alu_result_buf #(.W(W)) u_result_buf (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_data    (load_data),
    .load_kind    (load_kind),
    .load_allowed (load_allowed),
    .res_valid    (bus.res_valid),
    .res_ready    (bus.res_ready),
    .res_data     (bus.res_data),
    .res_kind     (bus.res_kind)
  );

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for TotalALU. Accepts one operation at a time from decode over a valid/ready handshake.
- Drives the ALU operand and control inputs (dataA, dataB, Signal) and holds them stable for the operation's full latency.
- For DIVU, runs the multi-cycle divide, then issues MFHI and MFLO itself.
- Returns every ALU result through a one-entry output buffer with backpressure.

Parameters:
- DIV_CYCLES, 33, cycles Signal=27 and the operands are held for a divide.
- DIV_SETTLE, 2, idle cycles between the end of the divide and MFHI.
- W, 32, datapath width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset (shared with TotalALU).
- op_valid  in  1  decode presents an operation.
- op_ready  out  1  controller accepts an operation this cycle.
- op_funct  in  6  function code: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT, 2 SRL, 27 DIVU.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- alu_dataA  out  W  to TotalALU dataA.
- alu_dataB  out  W  to TotalALU dataB.
- alu_signal  out  6  to TotalALU Signal.
- alu_out  in  W  from TotalALU Output.
- res_valid  out  1  result buffer holds a result.
- res_ready  in  1  consumer takes the result.
- res_data  out  W  result value.
- res_kind  out  2  0 normal, 1 HI, 2 LO, 3 error.

Behaviour:
- Reset (async): state IDLE; divide counter 0; alu_dataA/alu_dataB 0; alu_signal 0; res_valid 0; res_data 0; res_kind 0. op_ready is 1 once reset deasserts.
- Signal 0 means idle; the ALU output is ignored while alu_signal=0.
- op_ready = (state==IDLE). An operation is accepted on a clock edge where op_valid && op_ready. On that edge op_a, op_b and op_funct are registered into alu_dataA, alu_dataB and alu_signal.
- Buffer-free condition: capture is allowed when !res_valid || res_ready. This means the buffer can drain and refill on the same edge.
- FSM states: IDLE, EXEC, DIV_WAIT, DIV_SETTLE, MFHI, MFLO, ERR.
- IDLE -> EXEC on accept of 36, 37, 32, 34, 42 or 2.
- IDLE -> DIV_WAIT on accept of 27; counter loads DIV_CYCLES-1.
- IDLE -> ERR on accept of any other funct; alu_signal stays 0.
- EXEC: ALU inputs held. When capture is allowed: res_data<=alu_out, res_kind<=0, res_valid<=1, alu_signal<=0, go to IDLE. Otherwise stay in EXEC with inputs held.
- EXEC latency: accept at edge N gives res_valid high in cycle N+2 with no backpressure.
- DIV_WAIT: inputs and alu_signal=27 held. Counter decrements each cycle. When it reaches 0: alu_signal<=0, counter loads DIV_SETTLE-1, go to DIV_SETTLE.
- DIV_SETTLE: counts down to 0, then alu_signal<=16 and go to MFHI.
- MFHI: on capture, res_data<=alu_out, res_kind<=1, alu_signal<=18, go to MFLO.
- MFLO: on capture, res_kind<=2, alu_signal<=0, go to IDLE.
- DIVU timing with res_ready=1: accept at N; HI valid in cycle N+37; LO valid in N+38; op_ready=1 again in cycle N+38.
- ERR: on capture, res_data<=0, res_kind<=3, go to IDLE.
- Backpressure: never overwrites a valid, unconsumed result. The current state and all ALU inputs are held until capture is allowed. The divide counter does not stall; only capture states wait.
- Handshake rule: res_valid, res_data and res_kind stay stable while res_valid && !res_ready.
- Reset mid-operation: immediate return to reset values. Any pending HI/LO result is lost; the ALU aborts its divide through the shared reset.
- Simultaneous events: drain and capture on the same edge gives the new result valid on the next cycle with no bubble.
- op_valid while op_ready=0 is ignored; decode must hold the operation.

Decomposition:
- Package alu_pkg holds:
  - funct constants F_AND=36, F_OR=37, F_ADD=32, F_SUB=34, F_SLT=42, F_SRL=2, F_DIVU=27, F_MFHI=16, F_MFLO=18, F_IDLE=0;
  - the res_kind encoding;
  - the FSM state type.
- One natural sub-module, alu_result_buf: a one-entry valid/ready buffer with load and load_allowed outputs.

Test Plan:
- ADD 5,7 accepted at edge N -> alu_signal=32 in cycle N+1; res_valid in N+2; res_data=12, res_kind=0.
- SUB 3,5 -> res_data=32'hFFFFFFFE. Back-to-back SLT 3,5 offered immediately -> accepted when op_ready returns; result 1.
- DIVU 100,7 with res_ready=1:
  - alu_signal=27 for exactly 33 cycles, then 0 for 2 cycles, then 16, then 18;
  - HI=2 (kind 1) in N+37, LO=14 (kind 2) in N+38;
  - op_ready low for cycles N+1..N+37.
- DIVU 100,7 with res_ready=0 until 5 cycles after HI valid:
  - HI held stable throughout; alu_signal stays 18 while waiting;
  - LO=14 appears the cycle after HI is taken.
- op_funct=63 -> ALU never sees a non-zero signal; res_kind=3, res_data=0.
- Assert reset 10 cycles into a DIVU:
  - all outputs go to reset values asynchronously;
  - after release, ADD 1,1 -> 2 with no stale HI/LO result emitted.
